instr_issue_ctrl: RTL and testbench
===================================

Name: instr_issue_ctrl

Overview:
Upstream control stage for DATAPATH. It accepts one packed instruction at a time over a valid/ready handshake and decodes it. It then sequences the register-file read addresses, the ALU operation and the register write-back through a multi-cycle FSM. It also latches the ALU flags and counts retired instructions.

Parameters:
DATA_WIDTH, 64, register/ALU data width
ADDR_WIDTH, 8, register address width
OP_WIDTH, 8, opcode / alu_operation width
CNT_WIDTH, 32, retired-instruction counter width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
instr_valid  input  1  instruction present
instr_data  input  OP_WIDTH+3*ADDR_WIDTH  {opcode, rd, rs1, rs2}; imm = low 2*ADDR_WIDTH bits
instr_ready  output  1  block can accept an instruction
alu_result  input  DATA_WIDTH  ALU output from DATAPATH
zero_flag  input  1  ALU zero
negative_flag  input  1  ALU negative
overflow_flag  input  1  ALU overflow
reg_read_addr_1  output  ADDR_WIDTH  rs1 to register file
reg_read_addr_2  output  ADDR_WIDTH  rs2 to register file
reg_write_addr  output  ADDR_WIDTH  rd
reg_write_data  output  DATA_WIDTH  write-back value
reg_write_cmd  output  1  one-cycle write strobe
alu_operation  output  OP_WIDTH  ALU opcode
status_flags  output  3  {overflow, negative, zero} latched at EXECUTE
illegal_op  output  1  one-cycle pulse on an undefined opcode
halted  output  1  high after HALT until reset
retired_count  output  CNT_WIDTH  retired instructions

Behaviour:
- Reset: all outputs 0; state IDLE; instr_ready=1 from the first cycle after reset. A reset mid-operation aborts the instruction and drops reg_write_cmd at that edge. No partial write occurs.
- Opcode decode:
  - opcode[MSB]=0: ALU op. alu_operation=opcode; rd = rs1 op rs2.
  - 0x00: NOP.
  - 0x80: LDI. rd = sign-extended imm.
  - 0xFF: HALT.
  - Any other value with MSB=1 is illegal.
- States: IDLE, DECODE, EXECUTE, WRITEBACK, HALTED.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, capture instr_data → DECODE.
  - instr_ready is 0 in every other state; instr_data is ignored there.
- DECODE:
  - Drive reg_read_addr_1/2 = rs1/rs2 and alu_operation = opcode (ALU ops only, else 0).
  - Next state by opcode:
    - ALU op → EXECUTE.
    - LDI → WRITEBACK.
    - NOP → IDLE, retire.
    - HALT → HALTED, retire.
    - Illegal → IDLE with illegal_op=1 for exactly one cycle; not retired; no write.
- EXECUTE:
  - Read addresses and alu_operation are held stable.
  - At the clock edge, latch alu_result into the write-back register and latch the flags into status_flags → WRITEBACK.
- WRITEBACK:
  - reg_write_cmd=1 for exactly one cycle, with reg_write_addr=rd and reg_write_data = latched value.
  - retired_count increments → IDLE.
- HALTED: instr_ready=0 and halted=1; only reset exits.
- Outputs:
  - reg_write_addr and reg_write_data hold their last values outside WRITEBACK.
  - Read addresses hold their last values in IDLE.
  - status_flags changes only in EXECUTE; LDI and NOP leave it unchanged.
- Latency, with the handshake accepted at edge T:
  - ALU op: write strobe in cycle T+3; instr_ready high again in cycle T+4.
  - LDI: strobe in T+2; ready in T+3.
  - NOP and illegal: ready in T+2.
- retired_count wraps modulo 2^CNT_WIDTH with no saturation.
- rd=rs1=rs2 is legal; the read completes before the write.

Test Plan:
- Hold reset for 2 cycles, then release → all outputs 0, instr_ready=1, retired_count=0.
- LDI rd=0x02 imm=0xAAAA → reg_write_cmd pulses once 2 cycles after accept, addr 0x02, data 0xFFFFFFFFFFFFAAAA; retired_count=1.
- ADD (0x01) rd=0x04 rs1=0x02 rs2=0x03 with alu_result stub 0x6666666666666665, flags {1,0,0} → read addresses 0x02/0x03 and alu_operation 0x01 from T+1; write to 0x04 with that data at T+3; status_flags=3'b100.
- Opcode 0x85 → illegal_op high for exactly 1 cycle, no reg_write_cmd, retired_count unchanged; then SUB (0x02) executes normally.
- HALT then instr_valid held high → halted=1, instr_ready stays 0 and no further writes; reset → IDLE, halted=0.
- Assert reset during the EXECUTE of an ADD → no reg_write_cmd pulse ever occurs for that instruction; state returns to IDLE.

Source files
------------

// File: rtl/instr_issue_ctrl.sv
// instr_issue_ctrl: upstream issue/sequencing stage for DATAPATH.
// Accepts one packed instruction {opcode, rd, rs1, rs2} over valid/ready,
// decodes it, drives register-file read addresses and the ALU operation,
// then sequences a single write-back strobe. It also latches the ALU flags
// and counts retired instructions.
module instr_issue_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int OP_WIDTH   = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             instr_valid,
    input  logic [OP_WIDTH+3*ADDR_WIDTH-1:0] instr_data,
    output logic                             instr_ready,
    input  logic [DATA_WIDTH-1:0]            alu_result,
    input  logic                             zero_flag,
    input  logic                             negative_flag,
    input  logic                             overflow_flag,
    output logic [ADDR_WIDTH-1:0]            reg_read_addr_1,
    output logic [ADDR_WIDTH-1:0]            reg_read_addr_2,
    output logic [ADDR_WIDTH-1:0]            reg_write_addr,
    output logic [DATA_WIDTH-1:0]            reg_write_data,
    output logic                             reg_write_cmd,
    output logic [OP_WIDTH-1:0]              alu_operation,
    output logic [2:0]                       status_flags,
    output logic                             illegal_op,
    output logic                             halted,
    output logic [CNT_WIDTH-1:0]             retired_count
);

    localparam int INSTR_WIDTH = OP_WIDTH + 3 * ADDR_WIDTH;
    localparam int IMM_WIDTH   = 2 * ADDR_WIDTH;

    localparam logic [OP_WIDTH-1:0] OP_NOP  = '0;
    localparam logic [OP_WIDTH-1:0] OP_LDI  = {1'b1, {(OP_WIDTH-1){1'b0}}};
    localparam logic [OP_WIDTH-1:0] OP_HALT = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALTED
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_NOP,
        CLS_LDI,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    // Opcode classes: MSB clear is an ALU op (except all-zero NOP); with MSB
    // set only LDI and HALT are defined, everything else is illegal.
    function automatic op_class_t classify(input logic [OP_WIDTH-1:0] op);
        op_class_t cls;
        if (op == OP_NOP)
            cls = CLS_NOP;
        else if (!op[OP_WIDTH-1])
            cls = CLS_ALU;
        else if (op == OP_LDI)
            cls = CLS_LDI;
        else if (op == OP_HALT)
            cls = CLS_HALT;
        else
            cls = CLS_ILLEGAL;
        return cls;
    endfunction

    // Immediate occupies the rs1/rs2 fields and is sign-extended to the
    // full data width.
    function automatic logic [DATA_WIDTH-1:0] sign_extend_imm(input logic signed [IMM_WIDTH-1:0] imm);
        logic signed [DATA_WIDTH-1:0] ext;
        ext = imm;
        return ext;
    endfunction

    // ALU ops forward their opcode to the ALU; every other class drives 0.
    function automatic logic [OP_WIDTH-1:0] alu_op_of(input logic [OP_WIDTH-1:0] op);
        return op[OP_WIDTH-1] ? '0 : op;
    endfunction

    state_t state, next_state;

    logic [INSTR_WIDTH-1:0] instr_p0;
    logic [ADDR_WIDTH-1:0]  read_addr_1_p0;
    logic [ADDR_WIDTH-1:0]  read_addr_2_p0;
    logic [OP_WIDTH-1:0]    alu_op_p0;
    logic [ADDR_WIDTH-1:0]  wb_addr_p1;
    logic [DATA_WIDTH-1:0]  wb_data_p1;
    logic [2:0]             flags_p1;
    logic [CNT_WIDTH-1:0]   retired_q;

    logic accept;
    logic load_imm;
    logic load_alu;
    logic retire;

    logic [OP_WIDTH-1:0]   opcode_p0;
    logic [ADDR_WIDTH-1:0] rd_p0;
    logic [IMM_WIDTH-1:0]  imm_p0;
    op_class_t             class_p0;

    assign opcode_p0 = instr_p0[INSTR_WIDTH-1 -: OP_WIDTH];
    assign rd_p0     = instr_p0[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign imm_p0    = instr_p0[IMM_WIDTH-1:0];
    assign class_p0  = classify(opcode_p0);

    // State register; reset aborts any in-flight instruction.
    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic plus the one-cycle strobes and datapath load enables.
    always_comb begin
        next_state    = state;
        instr_ready   = 1'b0;
        reg_write_cmd = 1'b0;
        illegal_op    = 1'b0;
        halted        = 1'b0;
        accept        = 1'b0;
        load_imm      = 1'b0;
        load_alu      = 1'b0;
        retire        = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept     = 1'b1;
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (class_p0)
                    CLS_ALU: next_state = ST_EXECUTE;
                    CLS_LDI: begin
                        load_imm   = 1'b1;
                        next_state = ST_WRITEBACK;
                    end
                    CLS_NOP: begin
                        retire     = 1'b1;
                        next_state = ST_IDLE;
                    end
                    CLS_HALT: begin
                        retire     = 1'b1;
                        next_state = ST_HALTED;
                    end
                    default: begin
                        illegal_op = 1'b1;
                        next_state = ST_IDLE;
                    end
                endcase
            end
            ST_EXECUTE: begin
                load_alu   = 1'b1;
                next_state = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                reg_write_cmd = 1'b1;
                retire        = 1'b1;
                next_state    = ST_IDLE;
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Capture stage: the accepted instruction word, held until the next accept.
    always_ff @(posedge clock) begin
        if (accept)
            instr_p0 <= instr_data;
    end

    // Read addresses and ALU operation load on accept so they are valid in
    // DECODE and stay stable through EXECUTE and while idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            read_addr_1_p0 <= '0;
            read_addr_2_p0 <= '0;
            alu_op_p0      <= '0;
        end else if (accept) begin
            read_addr_1_p0 <= instr_data[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
            read_addr_2_p0 <= instr_data[ADDR_WIDTH-1:0];
            alu_op_p0      <= alu_op_of(instr_data[INSTR_WIDTH-1 -: OP_WIDTH]);
        end
    end

    // Write-back stage: value and destination load only on entry to
    // WRITEBACK, so the outputs hold their last values at all other times.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_addr_p1 <= '0;
            wb_data_p1 <= '0;
            flags_p1   <= '0;
        end else begin
            if (load_imm) begin
                wb_addr_p1 <= rd_p0;
                wb_data_p1 <= sign_extend_imm(imm_p0);
            end
            if (load_alu) begin
                wb_addr_p1 <= rd_p0;
                wb_data_p1 <= alu_result;
                flags_p1   <= {overflow_flag, negative_flag, zero_flag};
            end
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clock) begin
        if (reset)
            retired_q <= '0;
        else if (retire)
            retired_q <= retired_q + CNT_WIDTH'(1);
    end

    assign reg_read_addr_1 = read_addr_1_p0;
    assign reg_read_addr_2 = read_addr_2_p0;
    assign alu_operation   = alu_op_p0;
    assign reg_write_addr  = wb_addr_p1;
    assign reg_write_data  = wb_data_p1;
    assign status_flags    = flags_p1;
    assign retired_count   = retired_q;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Testbench for instr_issue_ctrl: directed table, hand-written corner
// sequences (HALT, reset mid-EXECUTE) and randomized instructions checked
// against a transaction-level reference model.
module tb_instr_issue_ctrl;

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic        instr_ready;
    logic [63:0] alu_result;
    logic        zero_flag;
    logic        negative_flag;
    logic        overflow_flag;
    logic [7:0]  reg_read_addr_1;
    logic [7:0]  reg_read_addr_2;
    logic [7:0]  reg_write_addr;
    logic [63:0] reg_write_data;
    logic        reg_write_cmd;
    logic [7:0]  alu_operation;
    logic [2:0]  status_flags;
    logic        illegal_op;
    logic        halted;
    logic [31:0] retired_count;

    instr_issue_ctrl #(
        .DATA_WIDTH(64), .ADDR_WIDTH(8), .OP_WIDTH(8), .CNT_WIDTH(32)
    ) dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
        .alu_result(alu_result), .zero_flag(zero_flag), .negative_flag(negative_flag),
        .overflow_flag(overflow_flag),
        .reg_read_addr_1(reg_read_addr_1), .reg_read_addr_2(reg_read_addr_2),
        .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
        .reg_write_cmd(reg_write_cmd), .alu_operation(alu_operation),
        .status_flags(status_flags), .illegal_op(illegal_op), .halted(halted),
        .retired_count(retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] alu;
        logic [2:0]  fl;       // {overflow, negative, zero}
        int          e_wr;     // number of write strobes
        int          e_wr_lat; // cycle of strobe after accept
        logic [7:0]  e_addr;
        logic [63:0] e_data;
        int          e_ill;    // number of illegal_op cycles
        int          e_rlat;   // cycle instr_ready returns
        logic [7:0]  e_aop;
        logic [2:0]  e_status;
        logic [31:0] e_ret;
    } vec_t;

    typedef struct {
        int          wr_cnt;
        int          wr_lat;
        logic [7:0]  wr_addr;
        logic [63:0] wr_data;
        int          ill_cnt;
        int          rdy_lat;
        logic [7:0]  r1;
        logic [7:0]  r2;
        logic [7:0]  aop;
    } obs_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference-model state
    logic [31:0] m_ret;
    logic [2:0]  m_status;
    logic [7:0]  m_last_addr;
    logic [63:0] m_last_data;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Spec-level model: outcome of one instruction from its opcode class.
    function automatic vec_t model(input logic [31:0] ins, input logic [63:0] alu, input logic [2:0] fl);
        vec_t v;
        logic [7:0] op;
        op = ins[31:24];
        v = '{ins, alu, fl, 0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 3'b000, 32'h0};
        if (op == 8'h00) begin
            v.e_rlat = 2;
            m_ret = m_ret + 1;
        end else if (op < 8'h80) begin
            v.e_wr = 1; v.e_wr_lat = 3; v.e_rlat = 4;
            v.e_addr = ins[23:16]; v.e_data = alu; v.e_aop = op;
            m_status = fl;
            m_ret = m_ret + 1;
        end else if (op == 8'h80) begin
            v.e_wr = 1; v.e_wr_lat = 2; v.e_rlat = 3;
            v.e_addr = ins[23:16]; v.e_data = {{48{ins[15]}}, ins[15:0]};
            m_ret = m_ret + 1;
        end else begin
            v.e_ill = 1; v.e_rlat = 2;
        end
        if (v.e_wr != 0) begin
            m_last_addr = v.e_addr;
            m_last_data = v.e_data;
        end
        v.e_status = m_status;
        v.e_ret    = m_ret;
        return v;
    endfunction

    // Present one instruction in IDLE, then observe until instr_ready returns.
    task automatic run_instr(input logic [31:0] ins, input logic [63:0] alu, input logic [2:0] fl,
                             input bit noise, output obs_t o);
        o = '{0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 8'h00, 8'h00};
        instr_valid = 1'b1;
        instr_data  = ins;
        alu_result  = alu;
        {overflow_flag, negative_flag, zero_flag} = fl;
        tick();
        if (noise) instr_data = $urandom;
        else       instr_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 1) begin
                o.r1  = reg_read_addr_1;
                o.r2  = reg_read_addr_2;
                o.aop = alu_operation;
            end
            if (reg_write_cmd) begin
                o.wr_cnt++;
                o.wr_lat  = k;
                o.wr_addr = reg_write_addr;
                o.wr_data = reg_write_data;
            end
            if (illegal_op) o.ill_cnt++;
            if (instr_ready) begin
                o.rdy_lat = k;
                break;
            end
            tick();
        end
        instr_valid = 1'b0;
    endtask

    task automatic check_vec(input string tag, input vec_t v, input obs_t o);
        chk({tag, ".wr_cnt"},   o.wr_cnt,  v.e_wr);
        if (v.e_wr != 0) begin
            chk({tag, ".wr_lat"},  o.wr_lat,  v.e_wr_lat);
            chk({tag, ".wr_addr"}, o.wr_addr, v.e_addr);
            chk({tag, ".wr_data"}, o.wr_data, v.e_data);
        end
        chk({tag, ".illegal"},  o.ill_cnt, v.e_ill);
        chk({tag, ".rdy_lat"},  o.rdy_lat, v.e_rlat);
        chk({tag, ".rd_addr1"}, o.r1,      v.instr[15:8]);
        chk({tag, ".rd_addr2"}, o.r2,      v.instr[7:0]);
        chk({tag, ".alu_op"},   o.aop,     v.e_aop);
        chk({tag, ".status"},   status_flags,   v.e_status);
        chk({tag, ".retired"},  retired_count,  v.e_ret);
        chk({tag, ".hold_addr"}, reg_write_addr, m_last_addr);
        chk({tag, ".hold_data"}, reg_write_data, m_last_data);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [7:0] op;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      op = 8'h00;
        else if (r <= 2) op = 8'h80;
        else if (r == 3) op = 8'(8'h81 + $urandom_range(0, 8'h7C));
        else             op = 8'(8'h01 + $urandom_range(0, 8'h7E));
        return {op, 24'($urandom)};
    endfunction

    localparam int NTBL = 8;
    vec_t tbl [NTBL];

    initial begin
        obs_t o;
        vec_t v;
        int   wr_seen, rdy_seen, halt_seen;

        tbl[0] = '{32'h8002AAAA, 64'h0, 3'b000, 1, 2, 8'h02, 64'hFFFFFFFFFFFFAAAA, 0, 3, 8'h00, 3'b000, 32'd1};
        tbl[1] = '{32'h01040203, 64'h6666666666666665, 3'b100, 1, 3, 8'h04, 64'h6666666666666665, 0, 4, 8'h01, 3'b100, 32'd2};
        tbl[2] = '{32'h85112233, 64'h0000000000000123, 3'b011, 0, 0, 8'h00, 64'h0, 1, 2, 8'h00, 3'b100, 32'd2};
        tbl[3] = '{32'h02050406, 64'h0, 3'b011, 1, 3, 8'h05, 64'h0, 0, 4, 8'h02, 3'b011, 32'd3};
        tbl[4] = '{32'h00FF1122, 64'hDEAD, 3'b100, 0, 0, 8'h00, 64'h0, 0, 2, 8'h00, 3'b011, 32'd4};
        tbl[5] = '{32'h80071234, 64'h0, 3'b000, 1, 2, 8'h07, 64'h1234, 0, 3, 8'h00, 3'b011, 32'd5};
        tbl[6] = '{32'h7FFF1010, 64'h8000000000000000, 3'b010, 1, 3, 8'hFF, 64'h8000000000000000, 0, 4, 8'h7F, 3'b010, 32'd6};
        tbl[7] = '{32'h80108000, 64'h0, 3'b101, 1, 2, 8'h10, 64'hFFFFFFFFFFFF8000, 0, 3, 8'h00, 3'b010, 32'd7};

        reset = 1'b1; instr_valid = 1'b0; instr_data = '0; alu_result = '0;
        zero_flag = 1'b0; negative_flag = 1'b0; overflow_flag = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst.ready",   instr_ready, 1);
        chk("rst.wcmd",    reg_write_cmd, 0);
        chk("rst.waddr",   reg_write_addr, 0);
        chk("rst.wdata",   reg_write_data, 0);
        chk("rst.raddr1",  reg_read_addr_1, 0);
        chk("rst.raddr2",  reg_read_addr_2, 0);
        chk("rst.aluop",   alu_operation, 0);
        chk("rst.status",  status_flags, 0);
        chk("rst.illegal", illegal_op, 0);
        chk("rst.halted",  halted, 0);
        chk("rst.retired", retired_count, 0);

        // Directed table
        m_last_addr = 8'h00;
        m_last_data = 64'h0;
        for (int i = 0; i < NTBL; i++) begin
            run_instr(tbl[i].instr, tbl[i].alu, tbl[i].fl, 1'b0, o);
            if (tbl[i].e_wr != 0) begin
                m_last_addr = tbl[i].e_addr;
                m_last_data = tbl[i].e_data;
            end
            check_vec($sformatf("tbl%0d", i), tbl[i], o);
        end
        m_ret    = tbl[NTBL-1].e_ret;
        m_status = tbl[NTBL-1].e_status;

        // Randomized instructions with garbage on instr_data while busy
        for (int i = 0; i < 150; i++) begin
            logic [31:0] ins;
            logic [63:0] alu;
            logic [2:0]  fl;
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            ins = rand_instr();
            alu = {$urandom, $urandom};
            fl  = 3'($urandom);
            v = model(ins, alu, fl);
            run_instr(ins, alu, fl, 1'($urandom_range(0, 1)), o);
            check_vec($sformatf("rnd%0d", i), v, o);
        end

        // HALT, then keep offering instructions
        instr_valid = 1'b1;
        instr_data  = 32'hFF000000;
        tick();
        instr_data  = 32'h01030102;
        wr_seen = 0; rdy_seen = 0; halt_seen = 0;
        for (int k = 1; k <= 12; k++) begin
            if (reg_write_cmd) wr_seen++;
            if (instr_ready)   rdy_seen++;
            if (halted)        halt_seen++;
            tick();
        end
        chk("halt.writes",   wr_seen, 0);
        chk("halt.ready",    rdy_seen, 0);
        chk("halt.halted",   halt_seen, 11);
        chk("halt.retired",  retired_count, m_ret + 32'd1);
        reset = 1'b1;
        instr_valid = 1'b0;
        tick();
        reset = 1'b0;
        chk("halt_rst.halted",  halted, 0);
        chk("halt_rst.ready",   instr_ready, 1);
        chk("halt_rst.retired", retired_count, 0);
        chk("halt_rst.status",  status_flags, 0);

        // Reset during EXECUTE of an ADD
        instr_valid = 1'b1;
        instr_data  = 32'h01090A0B;
        alu_result  = 64'h5555;
        {overflow_flag, negative_flag, zero_flag} = 3'b111;
        tick();
        instr_valid = 1'b0;
        tick();
        chk("exec.aluop",  alu_operation, 8'h01);
        chk("exec.raddr1", reg_read_addr_1, 8'h0A);
        chk("exec.raddr2", reg_read_addr_2, 8'h0B);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (reg_write_cmd) wr_seen++;
            tick();
        end
        chk("exec_rst.writes",  wr_seen, 0);
        chk("exec_rst.ready",   instr_ready, 1);
        chk("exec_rst.status",  status_flags, 0);
        chk("exec_rst.wdata",   reg_write_data, 0);
        chk("exec_rst.retired", retired_count, 0);

        // Normal operation resumes after the abort
        m_ret = 32'd0; m_status = 3'b000; m_last_addr = 8'h00; m_last_data = 64'h0;
        v = model(32'h01201F1F, 64'hCAFEF00D12345678, 3'b001);
        run_instr(32'h01201F1F, 64'hCAFEF00D12345678, 3'b001, 1'b0, o);
        check_vec("post_rst", v, o);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
